// File: rtl/entrada_buffer_if.sv
// Switch/key input bundle between the board inputs, the buffer and the UC.
interface entrada_buffer_if #(
  parameter int WIDTH = 18,
  parameter int DEPTH = 4
);
  logic [WIDTH-1:0]           entrada;
  logic                       enter;
  logic                       in;
  logic                       clr;
  logic [31:0]                valor;
  logic                       sinal;
  logic                       vazio;
  logic                       cheio;
  logic                       overflow;
  logic [$clog2(DEPTH):0]     nivel;

  modport master (
    output entrada, enter, in, clr,
    input  valor, sinal, vazio, cheio, overflow, nivel
  );

  modport slave (
    input  entrada, enter, in, clr,
    output valor, sinal, vazio, cheio, overflow, nivel
  );
endinterface

// File: rtl/entrada_buffer.sv
// Buffered switch input port: synchronises and debounces the enter key,
// queues one switch word per press and hands words to the UC on request.
module entrada_buffer #(
  parameter int WIDTH      = 18,
  parameter int DEPTH      = 4,
  parameter int DEB_CYCLES = 500000,
  parameter int SIGNED     = 1
) (
  input logic              clock,
  input logic              reset,
  entrada_buffer_if.slave  bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int NW = AW + 1;
  localparam int CW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;

  logic [WIDTH-1:0] sw_s1, sw_s;
  logic             key_s1, key_s;
  logic             key_db;
  logic [CW-1:0]    deb_cnt;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr, rptr;
  logic [NW-1:0]    count;
  logic             servido;
  logic             ovf;
  logic             sinal_r;
  logic [31:0]      valor_r;

  logic press, full, empty, pop, push, ovf_set, deb_done;

  function automatic logic [31:0] extend(input logic [WIDTH-1:0] w);
    if (SIGNED != 0) return 32'($signed(w));
    else             return 32'(w);
  endfunction

  // Press is the debounced 1->0 transition, recognised on the accepting edge.
  always_comb begin
    deb_done = (key_s != key_db) && (deb_cnt == CW'(DEB_CYCLES - 1));
    press    = deb_done && key_db && !key_s;
    full     = (count == NW'(DEPTH));
    empty    = (count == '0);
    pop      = bus.in && !servido && !empty && !bus.clr;
    // A pop on the same edge frees the slot, so a press into a full FIFO is still taken.
    push     = press && !bus.clr && (!full || pop);
    ovf_set  = press && !bus.clr && full && !pop;
  end

  // Two-flop synchronisers for the switch bank and the raw key.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sw_s1  <= '0;
      sw_s   <= '0;
      key_s1 <= 1'b1;
      key_s  <= 1'b1;
    end else begin
      sw_s1  <= bus.entrada;
      sw_s   <= sw_s1;
      key_s1 <= bus.enter;
      key_s  <= key_s1;
    end
  end

  // Debounce: accept a new key level only after DEB_CYCLES stable cycles.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      key_db  <= 1'b1;
      deb_cnt <= '0;
    end else if (key_s == key_db) begin
      deb_cnt <= '0;
    end else if (deb_done) begin
      key_db  <= key_s;
      deb_cnt <= '0;
    end else begin
      deb_cnt <= deb_cnt + 1'b1;
    end
  end

  // FIFO storage; contents need no reset since occupancy gates every read.
  always_ff @(posedge clock) begin
    if (push) mem[wptr] <= sw_s;
  end

  // FIFO pointers, occupancy, handshake and sticky overflow.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wptr    <= '0;
      rptr    <= '0;
      count   <= '0;
      servido <= 1'b0;
      ovf     <= 1'b0;
      sinal_r <= 1'b0;
      valor_r <= '0;
    end else if (bus.clr) begin
      wptr    <= '0;
      rptr    <= '0;
      count   <= '0;
      servido <= 1'b0;
      ovf     <= 1'b0;
      sinal_r <= 1'b0;
    end else begin
      sinal_r <= pop;
      if (push) wptr <= wptr + 1'b1;
      if (pop) begin
        rptr    <= rptr + 1'b1;
        valor_r <= extend(mem[rptr]);
      end
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
      if (!bus.in)  servido <= 1'b0;
      else if (pop) servido <= 1'b1;
      if (ovf_set) ovf <= 1'b1;
    end
  end

  // Status outputs derive only from registered state.
  always_comb begin
    bus.valor    = valor_r;
    bus.sinal    = sinal_r;
    bus.vazio    = empty;
    bus.cheio    = full;
    bus.overflow = ovf;
    bus.nivel    = count;
  end
endmodule

// File: tb/tb_entrada_buffer.sv
// Directed bench for entrada_buffer with DEB_CYCLES=4, DEPTH=4, WIDTH=18, SIGNED=1.
module tb_entrada_buffer;
  logic clock = 1'b0;
  logic reset = 1'b0;
  int unsigned checks = 0;
  int unsigned errors = 0;

  entrada_buffer_if #(.WIDTH(18), .DEPTH(4)) bus ();

  entrada_buffer #(
    .WIDTH(18), .DEPTH(4), .DEB_CYCLES(4), .SIGNED(1)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus(bus.slave)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [17:0] word;
    logic [31:0] exp_valor;
  } vec_t;

  vec_t vecs [6];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic press(input logic [17:0] w);
    @(negedge clock);
    bus.entrada = w;
    bus.enter   = 1'b0;
    repeat (8) @(negedge clock);
    bus.enter   = 1'b1;
    repeat (8) @(negedge clock);
  endtask

  task automatic deliver(input string nm, input logic [31:0] exp);
    int unsigned n = 0;
    logic got = 1'b0;
    logic extra = 1'b0;
    bus.in = 1'b1;
    while (!got && n < 10) begin
      @(negedge clock);
      n++;
      if (bus.sinal) got = 1'b1;
    end
    check({nm, " sinal"}, 32'(got), 32'd1);
    check({nm, " valor"}, bus.valor, exp);
    repeat (4) begin
      @(negedge clock);
      if (bus.sinal) extra = 1'b1;
    end
    check({nm, " single pulse"}, 32'(extra), 32'd0);
    bus.in = 1'b0;
    @(negedge clock);
  endtask

  task automatic check_reset_state(input string nm);
    check({nm, " valor"},    bus.valor,           32'd0);
    check({nm, " sinal"},    32'(bus.sinal),      32'd0);
    check({nm, " vazio"},    32'(bus.vazio),      32'd1);
    check({nm, " cheio"},    32'(bus.cheio),      32'd0);
    check({nm, " overflow"}, 32'(bus.overflow),   32'd0);
    check({nm, " nivel"},    32'(bus.nivel),      32'd0);
  endtask

  initial begin
    logic seen;
    vecs[0] = '{18'h2ABCD, 32'hFFFE_ABCD};
    vecs[1] = '{18'h1ABCD, 32'h0001_ABCD};
    vecs[2] = '{18'h3FFFF, 32'hFFFF_FFFF};
    vecs[3] = '{18'h20000, 32'hFFFE_0000};
    vecs[4] = '{18'h00000, 32'h0000_0000};
    vecs[5] = '{18'h1FFFF, 32'h0001_FFFF};

    bus.entrada = '0;
    bus.enter   = 1'b1;
    bus.in      = 1'b0;
    bus.clr     = 1'b0;
    repeat (3) @(negedge clock);
    check_reset_state("reset");
    reset = 1'b1;
    repeat (2) @(negedge clock);

    // Bounce: short low pulses never survive the debounce window.
    bus.entrada = 18'h2ABCD;
    for (int i = 0; i < 5; i++) begin
      bus.enter = 1'b0;
      repeat (2) @(negedge clock);
      bus.enter = 1'b1;
      repeat (2) @(negedge clock);
    end
    check("bounce no push", 32'(bus.nivel), 32'd0);
    bus.enter = 1'b0;
    repeat (10) @(negedge clock);
    bus.enter = 1'b1;
    repeat (8) @(negedge clock);
    check("bounce one push", 32'(bus.nivel), 32'd1);
    deliver("bounce", 32'hFFFE_ABCD);

    // Extension vectors.
    for (int i = 0; i < 6; i++) begin
      press(vecs[i].word);
      check($sformatf("vec%0d nivel", i), 32'(bus.nivel), 32'd1);
      deliver($sformatf("vec%0d", i), vecs[i].exp_valor);
      check($sformatf("vec%0d vazio", i), 32'(bus.vazio), 32'd1);
    end

    // Buffering and order.
    press(18'd1);
    press(18'd2);
    press(18'd3);
    check("order nivel", 32'(bus.nivel), 32'd3);
    deliver("order1", 32'd1);
    deliver("order2", 32'd2);
    deliver("order3", 32'd3);

    // Overflow and clr.
    for (int i = 1; i <= 5; i++) press(18'(i));
    check("ovf cheio",    32'(bus.cheio),    32'd1);
    check("ovf flag",     32'(bus.overflow), 32'd1);
    check("ovf nivel",    32'(bus.nivel),    32'd4);
    for (int i = 1; i <= 4; i++) deliver($sformatf("ovf rd%0d", i), 32'(i));
    check("ovf drained vazio", 32'(bus.vazio),    32'd1);
    check("ovf sticky",        32'(bus.overflow), 32'd1);
    press(18'd9);
    bus.clr = 1'b1;
    @(negedge clock);
    bus.clr = 1'b0;
    check("clr overflow", 32'(bus.overflow), 32'd0);
    check("clr vazio",    32'(bus.vazio),    32'd1);
    check("clr nivel",    32'(bus.nivel),    32'd0);
    check("clr valor held", bus.valor,       32'd4);

    // Stall then arrival, with exact latency.
    bus.in = 1'b1;
    seen = 1'b0;
    repeat (20) begin
      @(negedge clock);
      if (bus.sinal) seen = 1'b1;
    end
    check("stall no sinal", 32'(seen), 32'd0);
    bus.entrada = 18'd7;
    bus.enter   = 1'b0;
    repeat (6) @(negedge clock);
    check("arrive nivel after push", 32'(bus.nivel), 32'd1);
    check("arrive no early sinal",   32'(bus.sinal), 32'd0);
    @(negedge clock);
    check("arrive sinal", 32'(bus.sinal), 32'd1);
    check("arrive valor", bus.valor,      32'd7);
    check("arrive nivel", 32'(bus.nivel), 32'd0);
    bus.enter = 1'b1;
    @(negedge clock);
    check("arrive pulse width", 32'(bus.sinal), 32'd0);
    bus.in = 1'b0;
    repeat (8) @(negedge clock);

    // Simultaneous push and pop while full.
    for (int i = 10; i <= 13; i++) press(18'(i));
    check("full nivel", 32'(bus.nivel), 32'd4);
    bus.entrada = 18'd14;
    bus.enter   = 1'b0;
    repeat (5) @(negedge clock);
    bus.in = 1'b1;
    @(negedge clock);
    check("pushpop sinal",    32'(bus.sinal),    32'd1);
    check("pushpop valor",    bus.valor,         32'd10);
    check("pushpop cheio",    32'(bus.cheio),    32'd1);
    check("pushpop nivel",    32'(bus.nivel),    32'd4);
    check("pushpop overflow", 32'(bus.overflow), 32'd0);
    bus.in    = 1'b0;
    bus.enter = 1'b1;
    repeat (8) @(negedge clock);
    deliver("pushpop rd11", 32'd11);
    deliver("pushpop rd12", 32'd12);
    deliver("pushpop rd13", 32'd13);
    deliver("pushpop rd14", 32'd14);

    // Asynchronous reset mid-operation.
    press(18'h55);
    bus.enter = 1'b0;
    @(negedge clock);
    bus.in = 1'b1;
    #2 reset = 1'b0;
    #1 check_reset_state("async reset");
    bus.in    = 1'b0;
    bus.enter = 1'b1;
    @(negedge clock);
    reset = 1'b1;
    seen = 1'b0;
    repeat (10) begin
      @(negedge clock);
      if (bus.sinal) seen = 1'b1;
    end
    check("post reset no sinal", 32'(seen),      32'd0);
    check("post reset nivel",    32'(bus.nivel), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end
endmodule
